instr_realigner: RTL and testbench
==================================

# instr_realigner

Instruction realignment stage between the fetch unit and the compressed decoder. It accepts word-aligned 32-bit fetch words and splits or joins 16-bit halves into one instruction per handshake, holding a leftover upper half across words. The decoder receives a compressed instruction in bits [15:0] and a full instruction across all 32 bits, together with its PC. Branch redirects flush the held state and handle halfword-aligned targets.

## Interface
Parameters:
- BOOT_ADDR, 32'h0000_0080: PC after reset; bit 0 ignored.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- fetch_valid_i  input  1  fetch_rdata_i holds a valid word.
- fetch_rdata_i  input  32  fetch word, little-endian halves.
- fetch_ready_o  output  1  word consumed this cycle when high together with fetch_valid_i.
- branch_i  input  1  redirect pulse; the fetch unit flushes itself on this pulse.
- branch_addr_i  input  32  redirect target; bit 0 ignored.
- instr_valid_o  output  1  instr_rdata_o / instr_addr_o valid.
- instr_rdata_o  output  32  instruction; compressed is {16'h0000, half}.
- instr_addr_o  output  32  PC of instr_rdata_o.
- instr_compressed_o  output  1  instr_rdata_o[1:0] != 2'b11.
- id_ready_i  input  1  decoder accepts; handshake = instr_valid_o & id_ready_i.
- perf_cmp_cnt_o  output  32  count of compressed instructions handed over (see Configuration).

## Operation
- State registers:
  - res_q[15:0], res_valid_q: held upper half.
  - skip_q: drop the low half of the next word.
  - pc_q: current instruction PC.
- Modes, evaluated in priority order:
  - FLUSH (branch_i=1): instr_valid_o=0, fetch_ready_o=0. Next cycle: res_valid_q=0, skip_q=branch_addr_i[1], pc_q={branch_addr_i[31:1],1'b0}. Takes priority over any handshake in the same cycle.
  - RES_C (res_valid_q & res_q[1:0]!=11): output {16'h0,res_q}, valid without fetch; fetch_ready_o=0. On handshake: res_valid_q=0, pc+=2.
  - RES_F (res_valid_q & res_q[1:0]==11): instr_valid_o=fetch_valid_i; output {fetch_rdata_i[15:0],res_q}; fetch_ready_o=id_ready_i. On handshake: res_q=fetch_rdata_i[31:16], res_valid_q=1, pc+=4.
  - SKIP (!res_valid_q & skip_q): instr_valid_o=0; fetch_ready_o=1. On a fetch beat: res_q=fetch_rdata_i[31:16], res_valid_q=1, skip_q=0; pc unchanged.
  - ALIGNED (!res_valid_q & !skip_q): instr_valid_o=fetch_valid_i; fetch_ready_o=id_ready_i.
    - Low half compressed: output {16'h0,fetch_rdata_i[15:0]}. On handshake: res_q=fetch_rdata_i[31:16], res_valid_q=1, pc+=2.
    - Otherwise: output the full word. On handshake: pc+=4.
- PC arithmetic is mod 2^32; wrap from 32'hFFFF_FFFE to 0 is legal.
- Illegal-encoding checks are left to the decoder. All-zero halves pass through unchanged.

## Timing
- Outputs are combinational from the registers and the fetch inputs; fetch-to-instr latency is 0 cycles.
- A held compressed half costs one cycle with no fetch beat.
- A halfword-aligned branch target costs one SKIP cycle before the first instruction.
- Reset values:
  - Internal state: res_valid_q=0, skip_q=BOOT_ADDR[1], pc_q={BOOT_ADDR[31:1],0}.
  - Outputs: instr_valid_o=0, fetch_ready_o=0 during reset, perf_cmp_cnt_o=0.
  - Reset mid-operation discards the held half immediately.
- With id_ready_i=0, outputs hold stable as long as fetch_valid_i/fetch_rdata_i hold. fetch_valid_i must not drop before fetch_ready_o.
- Back-to-back full-word instructions sustain 1 instruction per cycle. A stream of straddled full instructions also sustains 1 per cycle in RES_F.

## Configuration
- REALIGN_PERF_CNT_EN defined:
  - perf_cmp_cnt_o increments on every handshake with instr_compressed_o=1.
  - Wraps at 2^32; not cleared by branch.
- Undefined: no counter register; perf_cmp_cnt_o tied to 32'h0.

## Test plan
- Reset with BOOT_ADDR=32'h80; fetch 32'h00A00093 -> one instruction 32'h00A00093 at 32'h80, compressed=0, pc 32'h84.
- Fetch 32'h4505_4501 -> 32'h4501 at 32'h80, then 32'h4505 at 32'h82 with fetch_ready_o=0 in that second cycle.
- Straddle: words 32'h0093_4501 then 32'h1234_00A0 -> 32'h4501 at 32'h80; then 32'h00A00093 at 32'h82 in RES_F; then residual 16'h1234 held.
- Branch to 32'h102 with a valid fetch word 32'h4581_FFFF -> SKIP cycle with no output, then 32'h4581 at 32'h102.
- id_ready_i=0 for 5 cycles in RES_C -> stable outputs, no pc change; branch_i during the stall -> output drops, held half discarded.
- With REALIGN_PERF_CNT_EN, the stream of scenario 2 -> perf_cmp_cnt_o=2. Without the macro -> 0.

Source files
------------

// File: rtl/instr_realigner.sv
// instr_realigner
//   Realigns word-aligned 32-bit fetch words into one instruction per
//   decoder handshake. A 16-bit compressed instruction is presented as
//   {16'h0, half}; a 32-bit instruction may straddle two fetch words, in
//   which case its lower half is held in res_q until the next word arrives.
//   Branch redirects drop the held half; a halfword-aligned target costs one
//   SKIP beat that discards the low half of the first fetched word.
//
//   Optional feature macro: REALIGN_PERF_CNT_EN
//     defined   -> perf_cmp_cnt_o counts compressed instruction handshakes
//     undefined -> perf_cmp_cnt_o is tied to zero
//
// Ports
//   clk_i, rst_ni               clock, async active-low reset
//   fetch_valid_i/rdata_i       incoming fetch word
//   fetch_ready_o               fetch word consumed when high with valid
//   branch_i, branch_addr_i     redirect pulse and target
//   instr_valid_o/rdata_o/addr_o/compressed_o  instruction to decoder
//   id_ready_i                  decoder accepts
//   perf_cmp_cnt_o              compressed instruction count
//
// mode    | meaning
// --------+-----------------------------------------------------------
// FLUSH   | redirect this cycle, nothing presented or consumed
// RES_C   | held half is a full compressed instruction, no fetch needed
// RES_F   | held half is the low half of a 32-bit instr, needs next word
// SKIP    | halfword-aligned target, drop low half of the next word
// ALIGNED | nothing held, instruction starts at bit 0 of the fetch word

module instr_realigner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_compressed_o,
  input  logic        id_ready_i,
  output logic [31:0] perf_cmp_cnt_o
);

  typedef enum logic [2:0] {
    FLUSH,
    RES_C,
    RES_F,
    SKIP,
    ALIGNED
  } mode_e;

  logic [15:0] res_q;
  logic        res_valid_q;
  logic        skip_q;
  logic [31:0] pc_q;

  mode_e       mode;
  logic        valid_raw;
  logic        ready_raw;
  logic        low_cmp;
  logic        hs;
  logic        beat;
  logic        unused_addr_bit0;

  assign unused_addr_bit0 = branch_addr_i[0];
  assign low_cmp          = (fetch_rdata_i[1:0] != 2'b11);

  always_comb begin
    mode = ALIGNED;
    if (branch_i)         mode = FLUSH;
    else if (res_valid_q) mode = (res_q[1:0] != 2'b11) ? RES_C : RES_F;
    else if (skip_q)      mode = SKIP;
  end

  always_comb begin
    valid_raw     = 1'b0;
    ready_raw     = 1'b0;
    instr_rdata_o = 32'h0;
    case (mode)
      RES_C: begin
        valid_raw     = 1'b1;
        instr_rdata_o = {16'h0000, res_q};
      end
      RES_F: begin
        valid_raw     = fetch_valid_i;
        ready_raw     = id_ready_i;
        instr_rdata_o = {fetch_rdata_i[15:0], res_q};
      end
      SKIP: begin
        ready_raw = 1'b1;
      end
      ALIGNED: begin
        valid_raw     = fetch_valid_i;
        ready_raw     = id_ready_i;
        instr_rdata_o = low_cmp ? {16'h0000, fetch_rdata_i[15:0]} : fetch_rdata_i;
      end
      default: ;
    endcase
  end

  // Reset gates the handshake outputs so a BOOT_ADDR with bit 1 set does not
  // advertise SKIP readiness while the block is held in reset.
  assign instr_valid_o      = valid_raw & rst_ni;
  assign fetch_ready_o      = ready_raw & rst_ni;
  assign instr_addr_o       = pc_q;
  assign instr_compressed_o = (instr_rdata_o[1:0] != 2'b11);

  assign hs   = instr_valid_o & id_ready_i;
  assign beat = fetch_valid_i & fetch_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q       <= 16'h0000;
      res_valid_q <= 1'b0;
      skip_q      <= BOOT_ADDR[1];
      pc_q        <= {BOOT_ADDR[31:1], 1'b0};
    end else begin
      case (mode)
        FLUSH: begin
          res_valid_q <= 1'b0;
          skip_q      <= branch_addr_i[1];
          pc_q        <= {branch_addr_i[31:1], 1'b0};
        end
        RES_C: begin
          if (hs) begin
            res_valid_q <= 1'b0;
            pc_q        <= pc_q + 32'd2;
          end
        end
        RES_F: begin
          // Upper half of the consumed word becomes the next held half.
          if (hs) begin
            res_q <= fetch_rdata_i[31:16];
            pc_q  <= pc_q + 32'd4;
          end
        end
        SKIP: begin
          if (beat) begin
            res_q       <= fetch_rdata_i[31:16];
            res_valid_q <= 1'b1;
            skip_q      <= 1'b0;
          end
        end
        ALIGNED: begin
          if (hs) begin
            if (low_cmp) begin
              res_q       <= fetch_rdata_i[31:16];
              res_valid_q <= 1'b1;
              pc_q        <= pc_q + 32'd2;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REALIGN_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       perf_q <= 32'h0;
    else if (hs && instr_compressed_o) perf_q <= perf_q + 32'd1;
  end

  assign perf_cmp_cnt_o = perf_q;
`else
  assign perf_cmp_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_realigner.sv
module tb_instr_realigner;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_rdata;
  logic        fetch_ready;
  logic        branch;
  logic [31:0] branch_addr;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;
  logic        instr_cmp;
  logic        id_ready;
  logic [31:0] perf;

  instr_realigner #(.BOOT_ADDR(BOOT)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .fetch_valid_i      (fetch_valid),
    .fetch_rdata_i      (fetch_rdata),
    .fetch_ready_o      (fetch_ready),
    .branch_i           (branch),
    .branch_addr_i      (branch_addr),
    .instr_valid_o      (instr_valid),
    .instr_rdata_o      (instr_rdata),
    .instr_addr_o       (instr_addr),
    .instr_compressed_o (instr_cmp),
    .id_ready_i         (id_ready),
    .perf_cmp_cnt_o     (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        cmp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[logic [31:0]];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cmp = 32'h0;

  logic [31:0] faddr;
  bit          fv_rand;
  int          ready_mode;
  logic        s_valid, s_fready;
  logic [31:0] s_data, s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(7))
      0:       h = 16'h0000;
      1, 2, 3: h[1:0] = 2'b11;
      default: if (h[1:0] == 2'b11) h[0] = 1'b0;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] get_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (!mem.exists(k)) mem[k] = {rand_half(), rand_half()};
    return mem[k];
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = get_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: walk the halfword stream from the target PC and cut it into
  // instructions by the low two bits of each starting half.
  function automatic void push_exp(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t        e;
    pc = {start[31:1], 1'b0};
    for (int i = 0; i < n; i++) begin
      h = half_at(pc);
      e.addr = pc;
      if (h[1:0] != 2'b11) begin
        e.data = {16'h0000, h};
        e.cmp  = 1'b1;
        pc     = pc + 32'd2;
      end else begin
        e.data = {half_at(pc + 32'd2), h};
        e.cmp  = 1'b0;
        pc     = pc + 32'd4;
      end
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && instr_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_instr actual=%h@%h required=none", instr_rdata, instr_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr_data", instr_rdata, e.data);
        chk("instr_addr", instr_addr, e.addr);
        chk("instr_cmp", {31'h0, instr_cmp}, {31'h0, e.cmp});
        // A compressed instr at an odd halfword comes from the held half
        // alone, so no fetch word may be consumed alongside it.
        chk("fetch_ready_at_hs", {31'h0, fetch_ready}, {31'h0, !(e.cmp && e.addr[1])});
        if (e.cmp) exp_cmp = exp_cmp + 32'd1;
      end
    end
  end

  task automatic cycle();
    bit beat;
    @(negedge clk);
    s_valid  = instr_valid;
    s_fready = fetch_ready;
    s_data   = instr_rdata;
    s_addr   = instr_addr;
    beat     = fetch_valid && fetch_ready;
    @(posedge clk);
    #1;
    if (branch) begin
      faddr       = {branch_addr[31:2], 2'b00};
      fetch_valid = 1'b0;
      branch      = 1'b0;
    end else if (beat) begin
      faddr       = faddr + 32'd4;
      fetch_valid = 1'b0;
    end
    if (!fetch_valid) fetch_valid = fv_rand ? ($urandom_range(3) != 0) : 1'b1;
    fetch_rdata = get_word(faddr);
    case (ready_mode)
      0:       id_ready = 1'b0;
      1:       id_ready = (exp_q.size() != 0);
      default: id_ready = (exp_q.size() != 0) && ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic do_branch(input logic [31:0] tgt, input int n);
    branch      = 1'b1;
    branch_addr = tgt;
    exp_q.delete();
    push_exp(tgt, n);
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      cycle();
      i++;
    end
    chk("drain_left", exp_q.size(), 32'h0);
  endtask

  task automatic chk_perf();
`ifdef REALIGN_PERF_CNT_EN
    chk("perf_cnt", perf, exp_cmp);
`else
    chk("perf_cnt", perf, 32'h0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    logic [31:0] tgt;
    mem[32'h80]  = 32'h00A0_0093;
    mem[32'h84]  = 32'h4505_4501;
    mem[32'h88]  = 32'h0093_4501;
    mem[32'h8C]  = 32'h1234_00A0;
    mem[32'h100] = 32'h4581_FFFF;
    mem[32'h200] = 32'h4505_4501;

    rst_n       = 1'b0;
    branch      = 1'b0;
    branch_addr = 32'h0;
    id_ready    = 1'b1;
    fv_rand     = 1'b0;
    ready_mode  = 1;
    faddr       = BOOT;
    fetch_valid = 1'b1;
    fetch_rdata = get_word(faddr);

    repeat (3) begin
      @(negedge clk);
      chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    end
    chk("rst_perf", perf, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(BOOT, 6);
    cycle();
    chk("boot_pc", s_addr, BOOT);
    chk("boot_valid", {31'h0, s_valid}, 32'h1);
    chk("boot_data", s_data, 32'h00A0_0093);
    drain(200);
    chk_perf();

    do_branch(32'h102, 4);
    cycle();
    chk("flush_valid", {31'h0, s_valid}, 32'h0);
    chk("flush_ready", {31'h0, s_fready}, 32'h0);
    cycle();
    chk("skip_valid", {31'h0, s_valid}, 32'h0);
    chk("skip_ready", {31'h0, s_fready}, 32'h1);
    drain(100);

    do_branch(32'h200, 6);
    cycle();
    i = 0;
    while (exp_q.size() > 5 && i < 20) begin
      cycle();
      i++;
    end
    chk("stall_reach", exp_q.size(), 32'h5);
    ready_mode = 0;
    id_ready   = 1'b0;
    repeat (5) begin
      cycle();
      chk("stall_valid", {31'h0, s_valid}, 32'h1);
      chk("stall_data", s_data, 32'h0000_4505);
      chk("stall_addr", s_addr, 32'h202);
      chk("stall_ready", {31'h0, s_fready}, 32'h0);
    end
    do_branch(32'h300, 10);
    cycle();
    chk("stall_flush_valid", {31'h0, s_valid}, 32'h0);
    ready_mode = 2;
    fv_rand    = 1'b1;
    drain(300);
    chk_perf();

    for (int s = 0; s < 30; s++) begin
      if (s % 7 == 6) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hE);
      else            tgt = 32'h1000 + ($urandom & 32'h3FE);
      do_branch(tgt, $urandom_range(4, 16));
      if ($urandom_range(2) == 0) repeat ($urandom_range(1, 6)) cycle();
      else                        drain(400);
    end
    do_branch(32'h2002, 8);
    drain(400);
    chk_perf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
